// File: rtl/cache_req_queue.sv
// Per-requester cache request queue: circular buffer whose head entry feeds one slice of the
// arbitrator's input buses. dealloc_in pops the head entry; clear_in flushes the queue.
module cache_req_queue #(
   parameter int CL_SIZE = 128,
   parameter int DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enq_valid,
   input  logic [31:0]              enq_addr,
   input  logic [CL_SIZE-1:0]       enq_data,
   input  logic [2:0]               enq_operation,
   input  logic [1:0]               enq_src,
   input  logic [1:0]               enq_dest,
   input  logic                     enq_is_flush,
   input  logic                     dealloc_in,
   input  logic                     clear_in,
   output logic                     valid_out,
   output logic [31:0]              addr_out,
   output logic [CL_SIZE-1:0]       data_out,
   output logic [2:0]               operation_out,
   output logic [1:0]               src_out,
   output logic [1:0]               dest_out,
   output logic                     is_flush_out,
   output logic                     full,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 32 + CL_SIZE + 3 + 2 + 2 + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(DEPTH - 1);

   logic [ENT_W-1:0] entry_q [DEPTH];
   logic [ENT_W-1:0] entry_d;
   logic [ENT_W-1:0] head;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             do_enq, do_pop, do_drop;

   assign valid_out   = (count_q != '0);
   assign full        = (count_q == DEPTH_C);
   assign almost_full = (count_q >= AFULL_C);
   assign count       = count_q;
   assign overflow    = overflow_q;

   // Head fields depend only on registered state, so dealloc_in can safely loop back from valid_out.
   assign head = entry_q[rd_ptr_q];
   assign {addr_out, data_out, operation_out, src_out, dest_out, is_flush_out} =
      valid_out ? head : '0;

   always_comb begin
      entry_d    = {enq_addr, enq_data, enq_operation, enq_src, enq_dest, enq_is_flush};
      do_pop     = dealloc_in && valid_out && !clear_in;
      do_enq     = enq_valid && (!full || do_pop) && !clear_in;
      do_drop    = enq_valid && full && !do_pop && !clear_in;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q || do_drop;
      if (clear_in) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_enq) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset; stale contents are masked while count is zero.
   always_ff @(posedge clk) begin
      if (do_enq) entry_q[wr_ptr_q] <= entry_d;
   end

endmodule
